// File: rtl/seq_rightshifter_pkg.sv
// Shared definitions for the multi-cycle right shifter.
// Holds the FSM state encoding and the default datapath widths used by the ALU.
// Optional feature macro consumed by the top: RSHIFT_NIBBLE_EN (4-bit shift steps).
package seq_rightshifter_pkg;

  // Default word width and shift-count width; DefWidth == 2**DefShw.
  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefShw   = 4;

  // Number of bit positions consumed by one nibble step.
  localparam int unsigned NibbleStep = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1
  } state_e;

endpackage

// File: rtl/seq_rightshifter_step.sv
// Combinational single-bit right-shift step.
// Ports:
//   in_i    - word to shift
//   fill_i  - bit inserted at the MSB
//   out_o   - word shifted right by one
//   shout_o - bit shifted out of the LSB
module seq_rightshifter_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] out_o,
  output logic             shout_o
);

  assign out_o   = {fill_i, in_i[WIDTH-1:1]};
  assign shout_o = in_i[0];

endmodule

// File: rtl/seq_rightshifter.sv
// Multi-cycle right shifter (logical or arithmetic) with a start/busy/done handshake.
// Shifts one bit per cycle; the last bit shifted out is returned as carry.
// Optional feature: define RSHIFT_NIBBLE_EN to shift by four bits per cycle while at least
// four positions remain. Results are identical; only latency changes.
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   reset_i  - synchronous active-high reset
//   start_i  - request, sampled only while idle
//   in_i     - operand, captured on the accepted start
//   amount_i - shift count, captured on the accepted start
//   arith_i  - 1: sign fill, 0: zero fill, captured on the accepted start
//   out_o    - result, held until the next accepted start
//   carry_o  - last bit shifted out (0 for a zero shift)
//   busy_o   - high from the accept edge until done
//   done_o   - one-cycle pulse when out_o/carry_o are valid
module seq_rightshifter
  import seq_rightshifter_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SHW   = DefShw
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [SHW-1:0]   amount_i,
  input  logic             arith_i,
  output logic [WIDTH-1:0] out_o,
  output logic             carry_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [SHW-1:0]   cnt_q;
  logic             mode_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic             fill;
  logic [WIDTH-1:0] step_out;
  logic             step_shout;

  // Sign fill keeps the MSB constant across steps, so one fill bit serves all positions.
  assign fill = mode_q & sh_q[WIDTH-1];

  seq_rightshifter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .in_i    (sh_q),
    .fill_i  (fill),
    .out_o   (step_out),
    .shout_o (step_shout)
  );

`ifdef RSHIFT_NIBBLE_EN
  logic [WIDTH-1:0] nib_out;
  logic             nib_shout;

  assign nib_out   = {{NibbleStep{fill}}, sh_q[WIDTH-1:NibbleStep]};
  assign nib_shout = sh_q[NibbleStep-1];
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sh_q    <= in_i;
            cnt_q   <= amount_i;
            mode_q  <= arith_i;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (cnt_q == '0) begin
            out_q   <= sh_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
`ifdef RSHIFT_NIBBLE_EN
            if (cnt_q >= SHW'(NibbleStep)) begin
              sh_q    <= nib_out;
              carry_q <= nib_shout;
              cnt_q   <= cnt_q - SHW'(NibbleStep);
            end else begin
              sh_q    <= step_out;
              carry_q <= step_shout;
              cnt_q   <= cnt_q - SHW'(1);
            end
`else
            sh_q    <= step_out;
            carry_q <= step_shout;
            cnt_q   <= cnt_q - SHW'(1);
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_o   = out_q;
  assign carry_o = carry_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
